// File: rtl/redmule_mx_pkg.sv
// Shared definitions for the MX decoder / FP16 packer datapath: element widths,
// row-buffer state encoding and the lane-to-element index helper.
package redmule_mx_pkg;

  localparam int unsigned MX_ELEM_W = 8;
  localparam int unsigned FP16_W    = 16;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

  function automatic int unsigned lane_elem_idx(input int unsigned beat,
                                                input int unsigned lane,
                                                input int unsigned num_lanes);
    return beat * num_lanes + lane;
  endfunction

endpackage

// File: rtl/redmule_mx_pack_buf.sv
// One row buffer of the FP16 packer: element data, per-element strobe and
// EMPTY/FILLING/FULL state. A clear empties the buffer and zeroes its contents.
module redmule_mx_pack_buf
  import redmule_mx_pkg::*;
#(
  parameter int unsigned BITW      = FP16_W,
  parameter int unsigned NUM_ELEMS = 32,
  parameter int unsigned NUM_LANES = 1,
  parameter int unsigned OFF_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  logic                          wr_en_i,
  input  logic                          wr_close_i,
  input  logic [OFF_W-1:0]              wr_off_i,
  input  logic [NUM_LANES*BITW-1:0]     wr_data_i,
  output logic [NUM_ELEMS*BITW-1:0]     data_o,
  output logic [NUM_ELEMS-1:0]          strb_o,
  output buf_state_e                    state_o
);

  localparam int unsigned LANE_W = NUM_LANES * BITW;
  localparam int unsigned OUT_W  = NUM_ELEMS * BITW;

  buf_state_e                state_r;
  buf_state_e                state_s;
  logic [OUT_W-1:0]          data_r;
  logic [NUM_ELEMS-1:0]      strb_r;

  // Next buffer state; a FULL buffer only leaves FULL through a clear.
  always_comb begin
    state_s = state_r;
    if (clr_i) begin
      state_s = BUF_EMPTY;
    end else begin
      case (state_r)
        BUF_EMPTY, BUF_FILLING: begin
          if (wr_en_i) begin
            state_s = wr_close_i ? BUF_FULL : BUF_FILLING;
          end else begin
            state_s = state_r;
          end
        end
        BUF_FULL: state_s = BUF_FULL;
        default:  state_s = BUF_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= BUF_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Element and strobe storage; lanes land at the element offset of the beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_r <= {OUT_W{1'b0}};
      strb_r <= {NUM_ELEMS{1'b0}};
    end else if (clr_i) begin
      data_r <= {OUT_W{1'b0}};
      strb_r <= {NUM_ELEMS{1'b0}};
    end else if (wr_en_i && (state_r != BUF_FULL)) begin
      data_r[wr_off_i*BITW +: LANE_W]  <= wr_data_i;
      strb_r[wr_off_i +: NUM_LANES]    <= {NUM_LANES{1'b1}};
    end else begin
      data_r <= data_r;
      strb_r <= strb_r;
    end
  end

  assign data_o  = data_r;
  assign strb_o  = strb_r;
  assign state_o = state_r;

endmodule

// File: rtl/redmule_mx_fp16_packer.sv
// Packs narrow FP16 beats from the MX decoder into full rows through a ping-pong
// buffer pair. Optional counters under `REDMULE_MX_PACKER_PERF_EN.
module redmule_mx_fp16_packer
  import redmule_mx_pkg::*;
#(
  parameter int unsigned BITW      = FP16_W,
  parameter int unsigned NUM_ELEMS = 32,
  parameter int unsigned NUM_LANES = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        fp16_valid_i,
  output logic                        fp16_ready_o,
  input  logic [NUM_LANES*BITW-1:0]   fp16_data_i,
  input  logic                        fp16_last_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NUM_ELEMS*BITW-1:0]   out_data_o,
  output logic [NUM_ELEMS-1:0]        out_strb_o
`ifdef REDMULE_MX_PACKER_PERF_EN
  ,
  output logic [31:0]                 stall_cnt_o,
  output logic [31:0]                 row_cnt_o
`endif
);

  localparam int unsigned NUM_GROUPS = NUM_ELEMS / NUM_LANES;
  localparam int unsigned OUT_W      = NUM_ELEMS * BITW;
  localparam int unsigned CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int unsigned OFF_W      = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  if ((NUM_ELEMS % NUM_LANES) != 0) begin : g_bad_lanes
    $fatal(1, "redmule_mx_fp16_packer: NUM_LANES must divide NUM_ELEMS");
  end

  logic                  wr_sel_r;
  logic                  rd_sel_r;
  logic [CNT_W-1:0]      beat_cnt_r;
  buf_state_e            st_s   [2];
  logic [OUT_W-1:0]      data_s [2];
  logic [NUM_ELEMS-1:0]  strb_s [2];
  logic                  wr_en_s  [2];
  logic                  clr_s    [2];
  logic                  xfer_s;
  logic                  close_s;
  logic                  hs_s;
  logic [OFF_W-1:0]      wr_off_s;

  assign wr_off_s = OFF_W'(lane_elem_idx(32'(beat_cnt_r), 32'd0, 32'(NUM_LANES)));

  // Handshakes and output mux; a soft clear discards both handshakes.
  always_comb begin
    fp16_ready_o = 1'b1;
    out_valid_o  = 1'b0;
    out_data_o   = {OUT_W{1'b0}};
    out_strb_o   = {NUM_ELEMS{1'b0}};
    fp16_ready_o = ((wr_sel_r ? st_s[1] : st_s[0]) != BUF_FULL);
    out_valid_o  = ((rd_sel_r ? st_s[1] : st_s[0]) == BUF_FULL);
    if (out_valid_o) begin
      out_data_o = rd_sel_r ? data_s[1] : data_s[0];
      out_strb_o = rd_sel_r ? strb_s[1] : strb_s[0];
    end else begin
      out_data_o = {OUT_W{1'b0}};
      out_strb_o = {NUM_ELEMS{1'b0}};
    end
    hs_s    = out_valid_o && out_ready_i && !clear_i;
    xfer_s  = fp16_valid_i && fp16_ready_o && !clear_i;
    close_s = xfer_s && ((beat_cnt_r == CNT_W'(NUM_GROUPS - 1)) || fp16_last_i);
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    assign wr_en_s[b] = xfer_s && (wr_sel_r == 1'(b));
    assign clr_s[b]   = clear_i || (hs_s && (rd_sel_r == 1'(b)));

    redmule_mx_pack_buf #(
      .BITW      (BITW),
      .NUM_ELEMS (NUM_ELEMS),
      .NUM_LANES (NUM_LANES),
      .OFF_W     (OFF_W)
    ) u_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_s[b]),
      .wr_en_i    (wr_en_s[b]),
      .wr_close_i (close_s),
      .wr_off_i   (wr_off_s),
      .wr_data_i  (fp16_data_i),
      .data_o     (data_s[b]),
      .strb_o     (strb_s[b]),
      .state_o    (st_s[b])
    );
  end

  // Write/read pointers and beat position within the row being filled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_sel_r   <= 1'b0;
      rd_sel_r   <= 1'b0;
      beat_cnt_r <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      wr_sel_r   <= 1'b0;
      rd_sel_r   <= 1'b0;
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (close_s) begin
        wr_sel_r   <= ~wr_sel_r;
        beat_cnt_r <= {CNT_W{1'b0}};
      end else if (xfer_s) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      if (hs_s) begin
        rd_sel_r <= ~rd_sel_r;
      end else begin
        rd_sel_r <= rd_sel_r;
      end
    end
  end

`ifdef REDMULE_MX_PACKER_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] row_cnt_r;

  // Saturating stall and completed-row counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= 32'd0;
      row_cnt_r   <= 32'd0;
    end else if (clear_i) begin
      stall_cnt_r <= 32'd0;
      row_cnt_r   <= 32'd0;
    end else begin
      if (out_valid_o && !out_ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (hs_s && (row_cnt_r != 32'hFFFF_FFFF)) begin
        row_cnt_r <= row_cnt_r + 32'd1;
      end else begin
        row_cnt_r <= row_cnt_r;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign row_cnt_o   = row_cnt_r;
`endif

endmodule

// File: tb/tb_redmule_mx_fp16_packer.sv
// Directed self-checking bench for redmule_mx_fp16_packer, one instance with a
// single lane and one with four lanes.
module tb_redmule_mx_fp16_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clr;
  logic         v1, r1, l1, ov1, or1;
  logic [15:0]  d1;
  logic [511:0] od1;
  logic [31:0]  os1;
  logic         v4, r4, l4, ov4, or4;
  logic [63:0]  d4;
  logic [511:0] od4;
  logic [31:0]  os4;
`ifdef REDMULE_MX_PACKER_PERF_EN
  logic [31:0]  stall1, rowc1, stall4, rowc4;
`endif

  int tests = 0;
  int errs  = 0;

  redmule_mx_fp16_packer #(.BITW(16), .NUM_ELEMS(32), .NUM_LANES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .fp16_valid_i(v1), .fp16_ready_o(r1), .fp16_data_i(d1), .fp16_last_i(l1),
    .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1), .out_strb_o(os1)
`ifdef REDMULE_MX_PACKER_PERF_EN
    , .stall_cnt_o(stall1), .row_cnt_o(rowc1)
`endif
  );

  redmule_mx_fp16_packer #(.BITW(16), .NUM_ELEMS(32), .NUM_LANES(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .fp16_valid_i(v4), .fp16_ready_o(r4), .fp16_data_i(d4), .fp16_last_i(l4),
    .out_valid_o(ov4), .out_ready_i(or4), .out_data_o(od4), .out_strb_o(os4)
`ifdef REDMULE_MX_PACKER_PERF_EN
    , .stall_cnt_o(stall4), .row_cnt_o(rowc4)
`endif
  );

  // Row whose first n elements are base, base+1, ... and the rest zero.
  function automatic logic [511:0] ramp(input logic [15:0] base, input int n);
    logic [511:0] r;
    r = 512'd0;
    for (int e = 0; e < n; e++) r[16*e +: 16] = base + 16'(e);
    return r;
  endfunction

  task automatic send1(input logic [15:0] base, input int n, input logic last_on_end);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v1 = 1'b1; d1 = base + 16'(i); l1 = last_on_end && (i == n - 1);
    end
    @(negedge clk);
    v1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0;
    v1 = 1'b0; d1 = 16'd0; l1 = 1'b0; or1 = 1'b0;
    v4 = 1'b0; d4 = 64'd0; l4 = 1'b0; or4 = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (ov1 !== 1'b0 || ov4 !== 1'b0) begin errs++; $display("FAIL reset_valid got %b/%b want 0/0", ov1, ov4); end
    tests++; if (od1 !== 512'd0 || os1 !== 32'd0) begin errs++; $display("FAIL reset_data strb got %h want 0", os1); end
    tests++; if (r1 !== 1'b1 || r4 !== 1'b1) begin errs++; $display("FAIL reset_ready got %b/%b want 1/1", r1, r4); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_row;
    logic rdy_ok;
    rdy_ok = 1'b1;
    or1 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (r1 !== 1'b1) rdy_ok = 1'b0;
      if (i == 31) begin
        tests++; if (ov1 !== 1'b0) begin errs++; $display("FAIL full_early_valid got %b want 0", ov1); end
      end
      v1 = 1'b1; d1 = 16'h3C00 + 16'(i); l1 = 1'b0;
    end
    @(negedge clk);
    v1 = 1'b0;
    tests++; if (!rdy_ok) begin errs++; $display("FAIL full_ready got 0 want 1"); end
    tests++; if (ov1 !== 1'b1) begin errs++; $display("FAIL full_latency got %b want 1", ov1); end
    tests++; if (od1 !== ramp(16'h3C00, 32)) begin errs++; $display("FAIL full_data got %h want %h", od1, ramp(16'h3C00, 32)); end
    tests++; if (os1 !== 32'hFFFF_FFFF) begin errs++; $display("FAIL full_strb got %h want ffffffff", os1); end
    @(negedge clk);
    tests++; if (ov1 !== 1'b0) begin errs++; $display("FAIL full_handoff got %b want 0", ov1); end
    or1 = 1'b0;
  endtask

  task automatic test_partial;
    or4 = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      v4 = 1'b1; l4 = (b == 2);
      for (int l = 0; l < 4; l++) d4[16*l +: 16] = 16'h1000 + 16'(4*b + l);
    end
    @(negedge clk);
    v4 = 1'b0; l4 = 1'b0;
    tests++; if (ov4 !== 1'b1) begin errs++; $display("FAIL partial_valid got %b want 1", ov4); end
    tests++; if (os4 !== 32'h0000_0FFF) begin errs++; $display("FAIL partial_strb got %h want 00000fff", os4); end
    tests++; if (od4 !== ramp(16'h1000, 12)) begin errs++; $display("FAIL partial_data got %h want %h", od4, ramp(16'h1000, 12)); end
    or4 = 1'b1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      v4 = 1'b1; l4 = (b == 7);
      for (int l = 0; l < 4; l++) d4[16*l +: 16] = 16'h2000 + 16'(4*b + l);
    end
    @(negedge clk);
    v4 = 1'b0; l4 = 1'b0;
    tests++; if (ov4 !== 1'b1 || os4 !== 32'hFFFF_FFFF) begin errs++; $display("FAIL partial_next_strb got %b/%h want 1/ffffffff", ov4, os4); end
    tests++; if (od4 !== ramp(16'h2000, 32)) begin errs++; $display("FAIL partial_next_data got %h want %h", od4, ramp(16'h2000, 32)); end
    repeat (2) @(negedge clk);
    tests++; if (ov4 !== 1'b0) begin errs++; $display("FAIL last_final_extra_row got %b want 0", ov4); end
    or4 = 1'b0;
  endtask

  task automatic test_stall;
    int acc, stall;
    logic stable_ok;
    acc = 0; stall = 0; stable_ok = 1'b1;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    or1 = 1'b0;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      if (ov1 && !or1) stall++;
      if (ov1 && od1[15:0] !== 16'h4000) stable_ok = 1'b0;
      v1 = 1'b1; d1 = 16'h4000 + 16'(acc);
      if (r1) acc++;
    end
    @(negedge clk);
    v1 = 1'b0;
    tests++; if (acc != 64) begin errs++; $display("FAIL stall_accepted got %0d want 64", acc); end
    tests++; if (r1 !== 1'b0) begin errs++; $display("FAIL stall_ready got %b want 0", r1); end
    tests++; if (!stable_ok) begin errs++; $display("FAIL stall_stable got changed want 4000"); end
`ifdef REDMULE_MX_PACKER_PERF_EN
    tests++; if (stall1 !== 32'(stall)) begin errs++; $display("FAIL perf_stall got %0d want %0d", stall1, stall); end
`endif
    tests++; if (ov1 !== 1'b1 || od1 !== ramp(16'h4000, 32)) begin errs++; $display("FAIL stall_row0 got %h want %h", od1, ramp(16'h4000, 32)); end
    or1 = 1'b1;
    @(negedge clk);
    tests++; if (r1 !== 1'b1) begin errs++; $display("FAIL stall_ready_rise got %b want 1", r1); end
    tests++; if (ov1 !== 1'b1 || od1 !== ramp(16'h4020, 32)) begin errs++; $display("FAIL stall_row1 got %h want %h", od1, ramp(16'h4020, 32)); end
    @(negedge clk);
    tests++; if (ov1 !== 1'b0) begin errs++; $display("FAIL stall_drain got %b want 0", ov1); end
`ifdef REDMULE_MX_PACKER_PERF_EN
    tests++; if (rowc1 !== 32'd2) begin errs++; $display("FAIL perf_rows got %0d want 2", rowc1); end
`endif
    or1 = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0]  q[$];
    logic [511:0] exp;
    int k, bidx, sent, rows_out, coinc;
    k = 0; bidx = 0; sent = 0; rows_out = 0; coinc = 0;
    for (int c = 0; c < 400 && rows_out < 6; c++) begin
      @(negedge clk);
      if (sent < 48) begin
        v4 = 1'b1; l4 = 1'b0;
        for (int l = 0; l < 4; l++) d4[16*l +: 16] = 16'h5000 + 16'(k + l);
      end else begin
        v4 = 1'b0;
      end
      if (sent >= 48) or4 = 1'b1;
      else if (sent < 16) or4 = ~or4;
      else or4 = (bidx == 7);
      if (v4 && r4) begin
        for (int l = 0; l < 4; l++) q.push_back(d4[16*l +: 16]);
        if (bidx == 7 && ov4 && or4) coinc++;
        k = k + 4; bidx = (bidx + 1) % 8; sent++;
      end
      if (ov4 && or4) begin
        exp = 512'd0;
        for (int e = 0; e < 32; e++) if (q.size() > 0) exp[16*e +: 16] = q.pop_front();
        tests++;
        if (od4 !== exp || os4 !== 32'hFFFF_FFFF) begin
          errs++; $display("FAIL b2b_row%0d got %h want %h", rows_out, od4, exp);
        end
        rows_out++;
      end
    end
    v4 = 1'b0; or4 = 1'b0;
    tests++; if (rows_out != 6 || q.size() != 0) begin errs++; $display("FAIL b2b_count got %0d rows %0d left want 6 rows 0 left", rows_out, q.size()); end
    tests++; if (coinc == 0) begin errs++; $display("FAIL b2b_coincide got 0 want >0"); end
  endtask

  task automatic test_clear;
    or1 = 1'b0;
    send1(16'h7000, 5, 1'b0);
    clr = 1'b1; v1 = 1'b1; d1 = 16'h7777;
    @(negedge clk);
    clr = 1'b0; v1 = 1'b0;
    tests++; if (ov1 !== 1'b0 || os1 !== 32'd0 || od1 !== 512'd0 || r1 !== 1'b1) begin errs++; $display("FAIL clear_midrow got %b/%h/%b want 0/0/1", ov1, os1, r1); end
    send1(16'h7100, 32, 1'b0);
    tests++; if (ov1 !== 1'b1) begin errs++; $display("FAIL clear_prefill got %b want 1", ov1); end
    or1 = 1'b1; clr = 1'b1; v1 = 1'b1; d1 = 16'h7EEE;
    @(negedge clk);
    clr = 1'b0; or1 = 1'b0; v1 = 1'b0;
    tests++; if (ov1 !== 1'b0 || r1 !== 1'b1 || os1 !== 32'd0) begin errs++; $display("FAIL clear_hs got %b/%b/%h want 0/1/0", ov1, r1, os1); end
    send1(16'h7200, 3, 1'b1);
    tests++; if (os1 !== 32'h0000_0007 || od1 !== ramp(16'h7200, 3)) begin errs++; $display("FAIL clear_restart got %h %h want 00000007 %h", os1, od1, ramp(16'h7200, 3)); end
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
  endtask

  task automatic test_async_rst;
    logic quiet_ok;
    quiet_ok = 1'b1;
    or1 = 1'b0;
    send1(16'h8000, 32, 1'b0);
    send1(16'h8100, 10, 1'b0);
    tests++; if (ov1 !== 1'b1) begin errs++; $display("FAIL arst_pre got %b want 1", ov1); end
    #2 rst = 1'b1;
    #1;
    tests++; if (ov1 !== 1'b0 || r1 !== 1'b1 || os1 !== 32'd0) begin errs++; $display("FAIL arst_immediate got %b/%b/%h want 0/1/0", ov1, r1, os1); end
    @(negedge clk);
    rst = 1'b0; or1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ov1 !== 1'b0) quiet_ok = 1'b0;
    end
    tests++; if (!quiet_ok) begin errs++; $display("FAIL arst_residual got 1 want 0"); end
    or1 = 1'b0;
    send1(16'h8200, 2, 1'b1);
    tests++; if (os1 !== 32'h0000_0003 || od1 !== ramp(16'h8200, 2)) begin errs++; $display("FAIL arst_restart got %h want 00000003", os1); end
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_partial();
    test_stall();
    test_back_to_back();
    test_clear();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/redmule_mx_fp16_packer.md
Name: redmule_mx_fp16_packer

Overview:
- Sits directly downstream of the MX decoder.
- Collects the decoder's narrow FP16 beats (NUM_LANES elements per beat, one beat per element group) into full-width FP16 rows and hands each row to the RedMulE engine input.
- Ping-pong double buffer, so the decoder streams at one beat per cycle while the engine stalls on the previous row.
- Supports early termination of a row (partial packet) with zero padding and an element strobe.

Parameters:
- BITW, 16, FP16 element width in bits.
- NUM_ELEMS, 32, elements per output row; equals the decoder's DATA_W/8.
- NUM_LANES, 1, elements per input beat; must divide NUM_ELEMS (fatal elaboration check otherwise).
- Derived localparams: NUM_GROUPS = NUM_ELEMS/NUM_LANES; OUT_W = NUM_ELEMS*BITW; CNT_W = max(1, clog2(NUM_GROUPS)).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous soft clear.
- fp16_valid_i  in  1  input beat valid.
- fp16_ready_o  out  1  input beat ready.
- fp16_data_i  in  NUM_LANES*BITW  lane l at bits [BITW*l +: BITW].
- fp16_last_i  in  1  this beat closes the row early.
- out_valid_o  out  1  row valid.
- out_ready_i  in  1  row ready.
- out_data_o  out  OUT_W  element e at bits [BITW*e +: BITW].
- out_strb_o  out  NUM_ELEMS  per-element written mask.

Behaviour:
- Reset values (async on rst_i high): out_valid_o=0, out_data_o=0, out_strb_o=0, fp16_ready_o=1. Both buffers EMPTY, contents and strobes zero. wr_sel=0, rd_sel=0, beat_cnt=0.
- Buffer states per buffer: EMPTY -> FILLING (first beat accepted) -> FULL (row closed) -> EMPTY (row handed off).
- Input handshake:
  - fp16_ready_o = 1 when buffer[wr_sel] is not FULL.
  - A transfer occurs when fp16_valid_i && fp16_ready_o.
  - ready does not depend on fp16_valid_i.
- Write on transfer:
  - Lane l goes to element beat_cnt*NUM_LANES+l of buffer[wr_sel].
  - The matching strobe bits are set.
- Row close:
  - Condition: a transfer with beat_cnt==NUM_GROUPS-1 or fp16_last_i=1.
  - Effect: buffer[wr_sel] becomes FULL, wr_sel toggles, beat_cnt returns to 0.
  - Otherwise beat_cnt increments.
  - Last on the final beat closes the row exactly once; it does not produce an extra empty row.
- Partial rows: unwritten elements read as 0 with strobe 0. A buffer is cleared to zero data and zero strobe when it is handed off.
- Output:
  - out_valid_o = (buffer[rd_sel] is FULL); out_data_o and out_strb_o are driven from buffer[rd_sel].
  - When out_valid_o=0, out_data_o=0 and out_strb_o=0.
  - On out_valid_o && out_ready_i: buffer[rd_sel] becomes EMPTY and rd_sel toggles.
- AXI-stream-like rules:
  - Once asserted, out_valid_o and out data/strb stay stable until the handshake.
  - out_valid_o never depends combinationally on out_ready_i.
- Latency: a row is valid the cycle after its closing beat is accepted.
- Throughput: sustained 1 beat/cycle when out_ready_i is held high.
- Simultaneous events:
  - Close of one buffer and hand-off of the other in the same cycle are both honoured.
  - Close and hand-off of the same buffer cannot occur together (FULL blocks writes).
- Both buffers FULL: fp16_ready_o=0 until a hand-off. The ready rises the cycle after the hand-off (registered state, no combinational ready path from out_ready_i).
- clear_i:
  - Same effect as reset, including dropping partial and full rows.
  - Has priority over any handshake in the same cycle; transfers in that cycle are discarded.
- Reset mid-row: the partial row is lost; no output is produced for it.

Optional Feature:
- Macro: REDMULE_MX_PACKER_PERF_EN.
- When defined, two extra outputs are present:
  - stall_cnt_o (32 bits): counts cycles with out_valid_o && !out_ready_i.
  - row_cnt_o (32 bits): counts completed output handshakes.
- Both counters saturate at all-ones and are zeroed by rst_i and clear_i.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package redmule_mx_pkg holds:
  - MX_ELEM_W=8 and FP16_W=16.
  - Buffer-state enum (EMPTY, FILLING, FULL).
  - Helper function for lane-to-element index.
- Sub-module redmule_mx_pack_buf, instantiated twice: one row buffer plus strobe register with beat write enable, element offset, clear and state.
- The top holds wr_sel/rd_sel/beat_cnt and the handshakes.

Test Plan:
- NUM_LANES=1, 32 beats with data 16'h3C00+i, out_ready_i=1 -> one row, element i = 3C00+i, strb=32'hFFFFFFFF, valid on the cycle after beat 31.
- NUM_LANES=4, 3 beats with last on beat 3 -> strb=32'h00000FFF, elements 12..31 = 0. A following full row has no stale data.
- out_ready_i=0 while 64 beats are offered -> exactly 64 accepted, then fp16_ready_o=0. Both rows later emerge in order with unchanged data. With PERF_EN, stall_cnt_o equals the stalled cycles.
- Back-to-back rows with out_ready_i toggling every cycle -> no beat lost or duplicated (scoreboard). Close and hand-off coincide at least once.
- clear_i asserted mid-row and together with an output handshake -> outputs return to reset values the next cycle. The next row starts at element 0.
- rst_i asserted asynchronously mid-row -> out_valid_o=0 and fp16_ready_o=1 immediately. No residual row after release.
